// File: rtl/fpnew_pkg.sv
// Shared FPU type definitions used by the divsqrt arbiter.
//   operation_e : FPU operation encoding (DIV/SQRT relevant here)
//   fp_format_e : floating-point destination format
//   roundmode_e : IEEE rounding mode
//   status_t    : IEEE exception flags {NV, DZ, OF, UF, NX}
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef struct packed {
    logic NV;
    logic DZ;
    logic OF;
    logic UF;
    logic NX;
  } status_t;

endpackage

// File: rtl/fpnew_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : index of the granted request (0 when no request)
//   valid_o : at least one request present
// Winner is the first set request at or above ptr_i, wrapping to the
// lowest set request below ptr_i when nothing is set at or above it.
module fpnew_rr_arbiter #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  // Requests at or above the pointer take priority over wrapped ones
  logic [NumReq-1:0] upper;

  always_comb begin
    upper = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      upper[i] = req_i[i] && (i >= int'(ptr_i));
    end
  end

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Downward scans leave the lowest matching index in idx_o; the
    // second scan overrides the wrapped choice when an upper request exists.
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IdxW'(i);
    end
    if (|upper) begin
      for (int i = int'(NumReq) - 1; i >= 0; i--) begin
        if (upper[i]) idx_o = IdxW'(i);
      end
    end
    gnt_o = '0;
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Shares one multi-cycle FP divide/sqrt unit between NumReq requesters.
// One operation is in flight at a time; grants are round-robin and the
// result is routed back to the requester that issued it.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   flush_i           : kill all activity (forwarded as unit_flush_o)
//   req_*             : per-requester issue port (valid/ready + fields)
//   unit_valid_o/...  : issue handshake and fields toward the unit
//   unit_valid_i/...  : result handshake from the unit
//   rsp_*             : response port, one-hot valid, shared data bus
//   busy_o            : an operation is held somewhere in the block
module fpnew_divsqrt_arbiter import fpnew_pkg::*; #(
  parameter  int unsigned NumReq  = 2,
  parameter  int unsigned Width   = 64,
  parameter  type         TagType = logic,
  localparam int unsigned IdxW    = $clog2(NumReq)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             flush_i,
  // requester issue ports
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq-1:0][1:0][Width-1:0] req_operands_i,
  input  operation_e [NumReq-1:0]          req_op_i,
  input  fp_format_e [NumReq-1:0]          req_fmt_i,
  input  roundmode_e [NumReq-1:0]          req_rnd_i,
  input  TagType [NumReq-1:0]              req_tag_i,
  // unit issue side
  output logic                             unit_valid_o,
  input  logic                             unit_ready_i,
  output logic [1:0][Width-1:0]            unit_operands_o,
  output operation_e                       unit_op_o,
  output fp_format_e                       unit_fmt_o,
  output roundmode_e                       unit_rnd_o,
  output logic                             unit_flush_o,
  // unit result side
  input  logic                             unit_valid_i,
  output logic                             unit_ready_o,
  input  logic [Width-1:0]                 unit_result_i,
  input  status_t                          unit_status_i,
  // response ports
  output logic [NumReq-1:0]                rsp_valid_o,
  input  logic [NumReq-1:0]                rsp_ready_i,
  output logic [Width-1:0]                 rsp_result_o,
  output status_t                          rsp_status_o,
  output TagType                           rsp_tag_o,
  output logic                             busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [1:0][Width-1:0] operands;
    operation_e            op;
    fp_format_e            fmt;
    roundmode_e            rnd;
    TagType                tag;
  } issue_t;

  typedef struct packed {
    logic [Width-1:0] result;
    status_t          status;
  } rsp_t;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  issue_t          issue_q, issue_d;
  rsp_t            rsp_q, rsp_d;

  logic [NumReq-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_valid;
  logic              kill;

  fpnew_rr_arbiter #(
    .NumReq (NumReq)
  ) i_arb (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Reset is gated in alongside flush so no grant or handshake is
  // advertised in a cycle whose state is about to be discarded.
  assign kill = flush_i | rst_i;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    issue_d      = issue_q;
    rsp_d        = rsp_q;
    req_ready_o  = '0;
    unit_valid_o = 1'b0;
    unit_ready_o = 1'b0;
    rsp_valid_o  = '0;

    case (state_q)
      IDLE: begin
        if (arb_valid && !kill) begin
          req_ready_o      = arb_gnt;
          owner_d          = arb_idx;
          issue_d.operands = req_operands_i[arb_idx];
          issue_d.op       = req_op_i[arb_idx];
          issue_d.fmt      = req_fmt_i[arb_idx];
          issue_d.rnd      = req_rnd_i[arb_idx];
          issue_d.tag      = req_tag_i[arb_idx];
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid_o = !kill;
        if (unit_ready_i) state_d = WAIT;
      end
      WAIT: begin
        unit_ready_o = !kill;
        if (unit_valid_i) begin
          rsp_d.result = unit_result_i;
          rsp_d.status = unit_status_i;
          state_d      = RESP;
        end
      end
      RESP: begin
        rsp_valid_o[owner_q] = !kill;
        // Only the owner's ready completes the response
        if (rsp_ready_i[owner_q]) begin
          rr_ptr_d = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides every transition; pointer and captured result keep
    // their old values so the dropped operation leaves no trace.
    if (flush_i) begin
      state_d  = IDLE;
      rr_ptr_d = rr_ptr_q;
      rsp_d    = rsp_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      issue_q  <= '0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      issue_q  <= issue_d;
      rsp_q    <= rsp_d;
    end
  end

  assign unit_operands_o = issue_q.operands;
  assign unit_op_o       = issue_q.op;
  assign unit_fmt_o      = issue_q.fmt;
  assign unit_rnd_o      = issue_q.rnd;
  assign unit_flush_o    = flush_i;

  assign rsp_result_o    = rsp_q.result;
  assign rsp_status_o    = rsp_q.status;
  assign rsp_tag_o       = issue_q.tag;

  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Directed bench for fpnew_divsqrt_arbiter with a stub divsqrt unit and
// a scoreboard of expected responses pushed at grant time.
module tb_fpnew_divsqrt_arbiter;
  import fpnew_pkg::*;

  localparam int NR = 2;
  localparam int W  = 64;
  typedef logic [3:0] tag_t;

  logic clk = 1'b0;
  logic rst, flush;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR-1:0][1:0][W-1:0] req_ops;
  operation_e [NR-1:0] req_op;
  fp_format_e [NR-1:0] req_fmt;
  roundmode_e [NR-1:0] req_rnd;
  tag_t [NR-1:0] req_tag;
  logic unit_vld_o, unit_rdy_i;
  logic [1:0][W-1:0] unit_ops;
  operation_e unit_op;
  fp_format_e unit_fmt;
  roundmode_e unit_rnd;
  logic unit_flush;
  logic unit_vld_i, unit_rdy_o;
  logic [W-1:0] unit_res;
  status_t unit_st;
  logic [NR-1:0] rsp_valid, rsp_ready;
  logic [W-1:0] rsp_res;
  status_t rsp_st;
  tag_t rsp_tag;
  logic busy;

  fpnew_divsqrt_arbiter #(.NumReq(NR), .Width(W), .TagType(tag_t)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_ops),
    .req_op_i(req_op), .req_fmt_i(req_fmt), .req_rnd_i(req_rnd), .req_tag_i(req_tag),
    .unit_valid_o(unit_vld_o), .unit_ready_i(unit_rdy_i), .unit_operands_o(unit_ops),
    .unit_op_o(unit_op), .unit_fmt_o(unit_fmt), .unit_rnd_o(unit_rnd),
    .unit_flush_o(unit_flush), .unit_valid_i(unit_vld_i), .unit_ready_o(unit_rdy_o),
    .unit_result_i(unit_res), .unit_status_i(unit_st),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_res),
    .rsp_status_o(rsp_st), .rsp_tag_o(rsp_tag), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         owner;
    logic [127:0] ops;
    logic [3:0] op;
    logic [W-1:0] res;
    logic [4:0] st;
    tag_t       tag;
  } exp_t;

  exp_t sb[$];
  int n_run = 0;
  int n_fail = 0;
  logic [1:0][W-1:0] iss_ops;
  operation_e iss_op;

  // Stub unit behaviour: DIV returns operand a, SQRT returns operand b
  function automatic logic [W-1:0] model(input operation_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    return (op == DIV) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input operation_e op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input tag_t t);
    req_ops[r][0] = a;
    req_ops[r][1] = b;
    req_op[r]     = op;
    req_fmt[r]    = FP32;
    req_rnd[r]    = RTZ;
    req_tag[r]    = t;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_unit_valid"}, unit_vld_o, 0);
    chk({tag, "_unit_ops"}, unit_ops, 0);
    chk({tag, "_unit_op"}, unit_op, 0);
    chk({tag, "_unit_fmt"}, unit_fmt, 0);
    chk({tag, "_unit_rnd"}, unit_rnd, 0);
    chk({tag, "_unit_ready"}, unit_rdy_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_res"}, rsp_res, 0);
    chk({tag, "_rsp_st"}, rsp_st, 0);
    chk({tag, "_rsp_tag"}, rsp_tag, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Expects IDLE with requests driven; checks the grant and pushes the
  // expected response, then crosses the acceptance edge.
  task automatic do_grant(input int w);
    exp_t e;
    logic [NR-1:0] oh;
    #1;
    oh = '0;
    oh[w] = 1'b1;
    chk("grant", req_ready, oh);
    chk("rsp_quiet_idle", rsp_valid, 0);
    e.owner = w;
    e.ops   = req_ops[w];
    e.op    = req_op[w];
    e.res   = model(req_op[w], req_ops[w][0], req_ops[w][1]);
    e.st    = req_ops[w][0][4:0];
    e.tag   = req_tag[w];
    sb.push_back(e);
    step();
  endtask

  task automatic do_issue(input int bp);
    exp_t e;
    e = sb[$];
    for (int i = 0; i <= bp; i++) begin
      unit_rdy_i = (i == bp);
      #1;
      chk("unit_valid", unit_vld_o, 1);
      chk("unit_ops", unit_ops, e.ops);
      chk("unit_op", unit_op, e.op);
      chk("unit_rnd", unit_rnd, RTZ);
      chk("req_ready_busy", req_ready, 0);
      iss_ops = unit_ops;
      iss_op  = unit_op;
      step();
    end
    unit_rdy_i = 1'b0;
  endtask

  task automatic do_unit(input int lat);
    for (int i = 0; i <= lat; i++) begin
      if (i == lat) begin
        unit_vld_i = 1'b1;
        unit_res   = model(iss_op, iss_ops[0], iss_ops[1]);
        unit_st    = status_t'(iss_ops[0][4:0]);
      end
      #1;
      chk("unit_ready", unit_rdy_o, 1);
      chk("unit_valid_low", unit_vld_o, 0);
      chk("rsp_not_yet", rsp_valid, 0);
      step();
    end
    unit_vld_i = 1'b0;
    unit_res   = '1;
    unit_st    = '1;
  endtask

  task automatic do_resp(input int bp);
    exp_t e;
    logic [NR-1:0] oh;
    e = sb.pop_front();
    oh = '0;
    oh[e.owner] = 1'b1;
    for (int i = 0; i <= bp; i++) begin
      rsp_ready = (i == bp) ? '1 : ~oh;
      #1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_res", rsp_res, e.res);
      chk("rsp_st", rsp_st, e.st);
      chk("rsp_tag", rsp_tag, e.tag);
      chk("unit_ready_resp", unit_rdy_o, 0);
      step();
    end
    rsp_ready = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; rsp_ready = '0;
    unit_rdy_i = 1'b0; unit_vld_i = 1'b0; unit_res = '0; unit_st = '0;
    req_ops = '0; req_tag = '0;
    for (int r = 0; r < NR; r++) set_req(r, DIV, '0, '0, '0);
    step();
    step();
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single request from requester 1
    set_req(1, DIV, 64'h4000_0000, 64'h3F80_0000, 4'd5);
    req_valid = 2'b10;
    do_grant(1);
    req_valid = '0;
    do_issue(0);
    do_unit(2);
    do_resp(0);
    #1;
    chk("single_done_busy", busy, 0);
    chk("single_done_rsp", rsp_valid, 0);

    // Contention from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, DIV,  64'h1111_0000_0000_0010, 64'h0000_0000_0000_0abc, 4'd1);
    set_req(1, SQRT, 64'h2222_0000_0000_0003, 64'h3333_4444_5555_6666, 4'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      do_grant(k % 2);
      // Alter the winner's inputs right after acceptance; the issue
      // registers must keep the captured values.
      set_req(k % 2, (k % 2 == 1) ? SQRT : DIV, 64'(64'h1000 + k * 16 + (k % 2)),
              64'(64'h7000 + k), tag_t'(k + 8));
      do_issue(0);
      do_unit(1);
      do_resp(0);
    end

    // Back-pressure on both sides, pointer advances once (0 -> 1)
    do_grant(0);
    do_issue(3);
    do_unit(0);
    do_resp(4);

    // Flush in WAIT, then a late unit result
    do_grant(1);
    req_valid = '0;
    do_issue(0);
    #1;
    chk("flush_wait_ready", unit_rdy_o, 1);
    step();
    flush = 1'b1;
    #1;
    chk("flush_unit_ready", unit_rdy_o, 0);
    chk("flush_fwd", unit_flush, 1);
    chk("flush_rsp", rsp_valid, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_busy", busy, 0);
    chk("flush_fwd_low", unit_flush, 0);
    unit_vld_i = 1'b1;
    unit_res   = 64'hDEAD_BEEF;
    #1;
    chk("late_unit_ready", unit_rdy_o, 0);
    step();
    unit_vld_i = 1'b0;
    #1;
    chk("late_rsp", rsp_valid, 0);
    chk("late_busy", busy, 0);
    void'(sb.pop_back());

    // Flush while requests wait in IDLE: no grant that cycle
    req_valid = 2'b11;
    flush = 1'b1;
    #1;
    chk("flush_idle_ready", req_ready, 0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_idle_busy", busy, 0);

    // Pointer unchanged by flush: requester 1 still has priority
    do_grant(1);
    req_valid = '0;
    do_issue(1);
    do_unit(0);
    do_resp(0);

    // Move pointer to 1, then reset while in RESP
    req_valid = 2'b01;
    do_grant(0);
    req_valid = '0;
    do_issue(0);
    do_unit(0);
    do_resp(0);
    req_valid = 2'b11;
    do_grant(1);
    req_valid = '0;
    do_issue(0);
    do_unit(0);
    #1;
    chk("pre_reset_rsp", rsp_valid, 2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    sb.delete();
    req_valid = 2'b11;
    do_grant(0);
    req_valid = '0;
    do_issue(0);
    do_unit(0);
    do_resp(0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
